// File: rtl/mem_loader.sv
// mem_loader: operator-driven memory initiator that latches two halfwords, writes the word, reads it back and verifies it
module mem_loader #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int BASE_ADDR = 0,
    parameter int LAST_ADDR = 127
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [15:0]       SW,
    input  logic              BTN_LO,
    input  logic              BTN_HI,
    input  logic              BTN_GO,
    output logic              CS,
    output logic              WE,
    output logic [ADDR_W-1:0] Address,
    inout  wire  [DATA_W-1:0] Mem_Bus,
    output logic              busy,
    output logic              verify_err,
    output logic [ADDR_W-1:0] count,
    output logic [15:0]       disp
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, CHECK} state_t;

    localparam int H = DATA_W / 2;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d, wdata_q, wdata_d, rb_q, rb_d;
    logic [ADDR_W-1:0] addr_q, addr_d, count_q, count_d;
    logic              err_q, err_d, cs_q, cs_d, we_q, we_d, hi_sel_q, hi_sel_d;
    logic              lo_prev_q, hi_prev_q, go_prev_q;
    logic              accept, lo_edge, hi_edge, go_edge;

    // Edge detection, halfword latching, commit sequencing and readback verification
    always_comb begin
        accept   = EN && state_q == IDLE;
        lo_edge  = accept && BTN_LO && !lo_prev_q;
        hi_edge  = accept && BTN_HI && !hi_prev_q;
        go_edge  = accept && BTN_GO && !go_prev_q;
        word_d   = word_q;
        wdata_d  = go_edge ? word_q : wdata_q;
        rb_d     = state_q == READ ? Mem_Bus : rb_q;
        addr_d   = addr_q;
        count_d  = count_q;
        err_d    = err_q;
        hi_sel_d = hi_edge ? 1'b1 : lo_edge ? 1'b0 : hi_sel_q;
        if (lo_edge) word_d[H-1:0] = SW;
        if (hi_edge) word_d[DATA_W-1:H] = SW;
        state_d = IDLE;
        if (EN) begin
            case (state_q)
                IDLE:    state_d = go_edge ? WRITE : IDLE;
                WRITE:   state_d = READ;
                READ:    state_d = CHECK;
                default: state_d = IDLE;
            endcase
        end
        if (EN && state_q == CHECK) begin
            if (rb_q == wdata_q) begin
                count_d = count_q + 1'b1;
                addr_d  = addr_q == LAST ? BASE : addr_q + 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        cs_d = state_d == WRITE || state_d == READ;
        we_d = state_d == WRITE;
    end

    // State and registered bus controls; reset releases the bus immediately
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            word_q    <= '0;
            wdata_q   <= '0;
            rb_q      <= '0;
            addr_q    <= BASE;
            count_q   <= '0;
            err_q     <= 1'b0;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            hi_sel_q  <= 1'b0;
            lo_prev_q <= 1'b0;
            hi_prev_q <= 1'b0;
            go_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            wdata_q   <= wdata_d;
            rb_q      <= rb_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            cs_q      <= cs_d;
            we_q      <= we_d;
            hi_sel_q  <= hi_sel_d;
            lo_prev_q <= BTN_LO;
            hi_prev_q <= BTN_HI;
            go_prev_q <= BTN_GO;
        end
    end

    // Gating with EN drops CS/WE and the bus driver in the same cycle EN falls
    assign CS         = cs_q && EN;
    assign WE         = we_q && EN;
    assign Mem_Bus    = WE ? wdata_q : {DATA_W{1'bz}};
    assign Address    = addr_q;
    assign count      = count_q;
    assign verify_err = err_q;
    assign busy       = state_q != IDLE;
    assign disp       = err_q ? 16'hEEEE
                      : busy ? {{(16-ADDR_W){1'b0}}, addr_q}
                      : hi_sel_q ? word_q[DATA_W-1:H] : word_q[H-1:0];
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed vector table plus hand sequences for hold, mismatch, EN abort, async reset and wrap
module tb_mem_loader;
    logic        CLK = 1'b0, RST = 1'b1, EN = 1'b0;
    logic [15:0] SW = '0;
    logic        BTN_LO = 1'b0, BTN_HI = 1'b0, BTN_GO = 1'b0;
    logic        CS, WE, busy, verify_err;
    logic [6:0]  Address, count;
    logic [15:0] disp;
    wire  [31:0] Mem_Bus;
    logic [31:0] mem [128];
    logic        force_zero = 1'b0;
    int          checks = 0, errors = 0;

    mem_loader dut (
        .CLK(CLK), .RST(RST), .EN(EN), .SW(SW), .BTN_LO(BTN_LO), .BTN_HI(BTN_HI), .BTN_GO(BTN_GO),
        .CS(CS), .WE(WE), .Address(Address), .Mem_Bus(Mem_Bus), .busy(busy),
        .verify_err(verify_err), .count(count), .disp(disp)
    );

    always #5 CLK = ~CLK;

    assign Mem_Bus = (CS && !WE) ? (force_zero ? 32'h0 : mem[Address]) : 32'hzzzzzzzz;

    always @(posedge CLK) if (CS && WE) mem[Address] <= Mem_Bus;

    typedef struct {
        logic        en;
        logic [15:0] sw;
        logic        lo, hi, go;
        logic [33:0] exp;
        logic        chk_bus;
        logic [31:0] bus;
    } vec_t;

    vec_t v [21];

    function automatic logic [33:0] e(input logic cs, we, bz, input logic [6:0] a, c,
                                      input logic err, input logic [15:0] d);
        return {cs, we, bz, a, c, err, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int nb;
        v[0]  = '{1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, e(0,0,0,0,0,0,16'h1234), 1'b0, 32'h0};
        v[1]  = '{1'b1, 16'hABCD, 1'b0, 1'b1, 1'b0, e(0,0,0,0,0,0,16'hABCD), 1'b0, 32'h0};
        v[2]  = '{1'b1, 16'hABCD, 1'b0, 1'b0, 1'b1, e(1,1,1,0,0,0,16'h0000), 1'b1, 32'hABCD1234};
        v[3]  = '{1'b1, 16'hABCD, 1'b0, 1'b0, 1'b1, e(1,0,1,0,0,0,16'h0000), 1'b0, 32'h0};
        v[4]  = '{1'b1, 16'hABCD, 1'b0, 1'b0, 1'b1, e(0,0,1,0,0,0,16'h0000), 1'b0, 32'h0};
        v[5]  = '{1'b1, 16'hABCD, 1'b0, 1'b0, 1'b1, e(0,0,0,1,1,0,16'hABCD), 1'b0, 32'h0};
        v[6]  = '{1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0, e(0,0,0,1,1,0,16'hABCD), 1'b0, 32'h0};
        v[7]  = '{1'b1, 16'h5555, 1'b1, 1'b0, 1'b1, e(1,1,1,1,1,0,16'h0001), 1'b1, 32'hABCD1234};
        v[8]  = '{1'b1, 16'h5555, 1'b1, 1'b0, 1'b1, e(1,0,1,1,1,0,16'h0001), 1'b0, 32'h0};
        v[9]  = '{1'b1, 16'h5555, 1'b1, 1'b0, 1'b1, e(0,0,1,1,1,0,16'h0001), 1'b0, 32'h0};
        v[10] = '{1'b1, 16'h5555, 1'b1, 1'b0, 1'b1, e(0,0,0,2,2,0,16'h5555), 1'b0, 32'h0};
        v[11] = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, e(0,0,0,2,2,0,16'h5555), 1'b0, 32'h0};
        v[12] = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, e(1,1,1,2,2,0,16'h0002), 1'b1, 32'hABCD5555};
        v[13] = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, e(1,0,1,2,2,0,16'h0002), 1'b0, 32'h0};
        v[14] = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, e(0,0,1,2,2,0,16'h0002), 1'b0, 32'h0};
        v[15] = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, e(0,0,0,3,3,0,16'h5555), 1'b0, 32'h0};
        v[16] = '{1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, e(0,0,0,3,3,0,16'h5555), 1'b0, 32'h0};
        v[17] = '{1'b0, 16'h1111, 1'b1, 1'b0, 1'b1, e(0,0,0,3,3,0,16'h5555), 1'b0, 32'h0};
        v[18] = '{1'b1, 16'h1111, 1'b1, 1'b0, 1'b1, e(0,0,0,3,3,0,16'h5555), 1'b0, 32'h0};
        v[19] = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, e(0,0,0,3,3,0,16'h5555), 1'b0, 32'h0};
        v[20] = '{1'b1, 16'h7777, 1'b1, 1'b1, 1'b0, e(0,0,0,3,3,0,16'h7777), 1'b0, 32'h0};

        step();
        chk("reset_state", 64'({CS, WE, busy, Address, count, verify_err, disp}), 64'(e(0,0,0,0,0,0,16'h0)));
        RST = 1'b0;
        step();
        for (int i = 0; i < 21; i++) begin
            EN = v[i].en; SW = v[i].sw; BTN_LO = v[i].lo; BTN_HI = v[i].hi; BTN_GO = v[i].go;
            step();
            chk($sformatf("vec%0d", i), 64'({CS, WE, busy, Address, count, verify_err, disp}), 64'(v[i].exp));
            if (v[i].chk_bus) chk($sformatf("vec%0d_bus", i), 64'(Mem_Bus), 64'(v[i].bus));
        end

        BTN_LO = 1'b0; BTN_HI = 1'b0; step();
        BTN_GO = 1'b1; nb = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (busy) nb++;
        end
        chk("hold_busy_cycles", 64'(nb), 64'd3);
        chk("hold_count", 64'(count), 64'd4);
        chk("hold_addr", 64'(Address), 64'd4);
        chk("mem0", 64'(mem[0]), 64'hABCD1234);
        chk("mem2", 64'(mem[2]), 64'hABCD5555);
        chk("mem3", 64'(mem[3]), 64'h77777777);

        BTN_GO = 1'b0; SW = 16'h0005; BTN_LO = 1'b1; step();
        BTN_LO = 1'b0; SW = 16'h0000; BTN_HI = 1'b1; step();
        BTN_HI = 1'b0; step();
        force_zero = 1'b1; BTN_GO = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("mismatch_err", 64'(verify_err), 64'd1);
        chk("mismatch_addr", 64'(Address), 64'd4);
        chk("mismatch_count", 64'(count), 64'd4);
        chk("mismatch_disp", 64'(disp), 64'hEEEE);
        BTN_GO = 1'b0; force_zero = 1'b0; step();
        BTN_GO = 1'b1; step();
        chk("retry_write", 64'({CS, WE, Address}), 64'({2'b11, 7'd4}));
        chk("retry_bus", 64'(Mem_Bus), 64'h5);
        for (int i = 0; i < 3; i++) step();
        chk("retry_done", 64'({Address, count, verify_err, disp}), 64'({7'd5, 7'd5, 1'b1, 16'hEEEE}));
        chk("mem4", 64'(mem[4]), 64'h5);

        BTN_GO = 1'b0; step();
        BTN_GO = 1'b1; step();
        step();
        chk("en_read", 64'({CS, WE, busy}), 64'b101);
        EN = 1'b0;
        #1;
        chk("en_drop_cs", 64'({CS, WE}), 64'b00);
        step();
        chk("en_drop_idle", 64'({busy, Address, count}), 64'({1'b0, 7'd5, 7'd5}));
        EN = 1'b1; BTN_GO = 1'b0; step();

        BTN_GO = 1'b1; step();
        chk("rst_pre_write", 64'({CS, WE}), 64'b11);
        #2 RST = 1'b1;
        #1;
        chk("async_reset", 64'({CS, WE, busy, Address, count, verify_err, disp}), 64'(e(0,0,0,0,0,0,16'h0)));
        BTN_GO = 1'b0;
        step();
        RST = 1'b0;
        step();

        for (int i = 1; i <= 128; i++) begin
            SW = 16'(i); BTN_LO = 1'b1; step();
            BTN_LO = 1'b0; BTN_GO = 1'b1;
            for (int k = 0; k < 4; k++) step();
            BTN_GO = 1'b0;
            if (i == 127) chk("wrap_127", 64'({Address, count}), 64'({7'd127, 7'd127}));
        end
        chk("wrap_128", 64'({Address, count, verify_err}), 64'({7'd0, 7'd0, 1'b0}));
        chk("wrap_mem127", 64'(mem[127]), 64'h80);
        chk("wrap_mem0", 64'(mem[0]), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
